// File: rtl/ahb_txn_queue.sv
// ahb_txn_queue: host command FIFO feeding an AHB master transaction port, plus a
// response FIFO that captures the master's unstallable read-data pulses. Read credits
// (outstanding reads + buffered responses) keep a response slot reserved for every
// read in flight.
module ahb_txn_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk_ahb,
    input  logic             i_rst_ahb,
    // Host command side
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [31:0]      i_req_addr,
    input  logic             i_req_rd0_wr1,
    input  logic [31:0]      i_req_wr_data,
    // Host response side
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    // AHB master transaction side
    output logic [31:0]      o_addr,
    output logic             o_rd0_wr1,
    output logic [31:0]      o_wr_data,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic             i_rd_valid,
    input  logic [31:0]      i_rd_data,
    // Status
    output logic [LVL_W-1:0] o_cmd_level,
    output logic [LVL_W-1:0] o_rsp_level,
    output logic             o_busy,
    output logic             o_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CMD_W = 65;

    // Credit limit widened by one bit so outstanding + rsp_level cannot overflow.
    localparam logic [LVL_W:0] CREDIT_MAX = (LVL_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Command FIFO state
    // ------------------------------------------------------------------
    logic [CMD_W-1:0] cmd_mem [DEPTH];
    logic [LVL_W-1:0] cmd_wptr_q, cmd_wptr_d;
    logic [LVL_W-1:0] cmd_rptr_q, cmd_rptr_d;
    logic [LVL_W-1:0] cmd_level;
    logic             cmd_empty;
    logic             cmd_full;
    logic             cmd_push;
    logic             cmd_pop;
    logic [CMD_W-1:0] cmd_head;
    logic             head_is_wr;

    // ------------------------------------------------------------------
    // Response FIFO state
    // ------------------------------------------------------------------
    logic [31:0]      rsp_mem [DEPTH];
    logic [LVL_W-1:0] rsp_wptr_q, rsp_wptr_d;
    logic [LVL_W-1:0] rsp_rptr_q, rsp_rptr_d;
    logic [LVL_W-1:0] rsp_level;
    logic             rsp_empty;
    logic             rsp_push;
    logic             rsp_pop;

    // ------------------------------------------------------------------
    // Credit / error state
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] outstanding_q, outstanding_d;
    logic             err_q, err_d;
    logic [LVL_W:0]   credit_used;
    logic             issue_ok;
    logic             rd_issue;
    logic             rd_orphan;
    logic             req_ready;
    logic             cmd_valid;

    // FIFO occupancy and flags; pointers wrap modulo 2*DEPTH so the MSB tells full from empty.
    always_comb begin
        cmd_level = cmd_wptr_q - cmd_rptr_q;
        cmd_empty = (cmd_wptr_q == cmd_rptr_q);
        cmd_full  = (cmd_wptr_q[LVL_W-1] != cmd_rptr_q[LVL_W-1]) &&
                    (cmd_wptr_q[AW-1:0] == cmd_rptr_q[AW-1:0]);
        rsp_level = rsp_wptr_q - rsp_rptr_q;
        rsp_empty = (rsp_wptr_q == rsp_rptr_q);
    end

    // Issue gating: a read may only leave when a response slot is guaranteed for it.
    always_comb begin
        cmd_head    = cmd_mem[cmd_rptr_q[AW-1:0]];
        head_is_wr  = cmd_head[CMD_W-1];
        credit_used = {1'b0, outstanding_q} + {1'b0, rsp_level};
        issue_ok    = head_is_wr || (credit_used < CREDIT_MAX);
        req_ready   = !cmd_full && !i_rst_ahb;
        cmd_valid   = !cmd_empty && issue_ok && !i_rst_ahb;
    end

    // Handshake decode for both FIFOs and the read-return path.
    always_comb begin
        cmd_push  = i_req_valid && req_ready;
        cmd_pop   = cmd_valid && i_ready;
        rd_issue  = cmd_pop && !head_is_wr;
        // Read data is only accepted while a read is actually in flight.
        rsp_push  = i_rd_valid && (outstanding_q != '0);
        rd_orphan = i_rd_valid && (outstanding_q == '0);
        rsp_pop   = !rsp_empty && !i_rst_ahb && i_rsp_ready;
    end

    // Next-state for pointers, read credits and the sticky error flag.
    always_comb begin
        cmd_wptr_d    = cmd_wptr_q;
        cmd_rptr_d    = cmd_rptr_q;
        rsp_wptr_d    = rsp_wptr_q;
        rsp_rptr_d    = rsp_rptr_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        if (cmd_push) cmd_wptr_d = cmd_wptr_q + LVL_W'(1);
        if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + LVL_W'(1);
        if (rsp_push) rsp_wptr_d = rsp_wptr_q + LVL_W'(1);
        if (rsp_pop)  rsp_rptr_d = rsp_rptr_q + LVL_W'(1);

        // Issue and return in the same cycle cancel out.
        case ({rd_issue, rsp_push})
            2'b10:   outstanding_d = outstanding_q + LVL_W'(1);
            2'b01:   outstanding_d = outstanding_q - LVL_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (rd_orphan) err_d = 1'b1;
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            cmd_wptr_q    <= '0;
            cmd_rptr_q    <= '0;
            rsp_wptr_q    <= '0;
            rsp_rptr_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            cmd_wptr_q    <= cmd_wptr_d;
            cmd_rptr_q    <= cmd_rptr_d;
            rsp_wptr_q    <= rsp_wptr_d;
            rsp_rptr_q    <= rsp_rptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Command storage write; contents are not reset, only the pointers are.
    always_ff @(posedge i_clk_ahb) begin
        if (cmd_push) begin
            cmd_mem[cmd_wptr_q[AW-1:0]] <= {i_req_rd0_wr1, i_req_addr, i_req_wr_data};
        end
    end

    // Response storage write; credits guarantee a free slot whenever rsp_push fires.
    always_ff @(posedge i_clk_ahb) begin
        if (rsp_push && !i_rst_ahb) begin
            rsp_mem[rsp_wptr_q[AW-1:0]] <= i_rd_data;
        end
    end

    // Output drive; status is forced to idle values while reset is held.
    always_comb begin
        o_req_ready = req_ready;
        o_valid     = cmd_valid;
        o_rd0_wr1   = cmd_head[CMD_W-1];
        o_addr      = cmd_head[63:32];
        o_wr_data   = cmd_head[31:0];
        o_rsp_valid = !rsp_empty && !i_rst_ahb;
        o_rsp_data  = rsp_mem[rsp_rptr_q[AW-1:0]];
        o_cmd_level = i_rst_ahb ? '0 : cmd_level;
        o_rsp_level = i_rst_ahb ? '0 : rsp_level;
        o_busy      = (!cmd_empty || (outstanding_q != '0)) && !i_rst_ahb;
        o_err       = err_q && !i_rst_ahb;
    end

endmodule

// File: tb/tb_ahb_txn_queue.sv
// Bench for ahb_txn_queue: directed scenarios followed by a randomized phase, all
// checked every cycle against a queue-based transaction model of the block.
module tb_ahb_txn_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    logic             i_clk_ahb = 1'b0;
    logic             i_rst_ahb;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [31:0]      i_req_addr;
    logic             i_req_rd0_wr1;
    logic [31:0]      i_req_wr_data;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_data;
    logic [31:0]      o_addr;
    logic             o_rd0_wr1;
    logic [31:0]      o_wr_data;
    logic             o_valid;
    logic             i_ready;
    logic             i_rd_valid;
    logic [31:0]      i_rd_data;
    logic [LVL_W-1:0] o_cmd_level;
    logic [LVL_W-1:0] o_rsp_level;
    logic             o_busy;
    logic             o_err;

    ahb_txn_queue #(
        .DEPTH(DEPTH),
        .LVL_W(LVL_W)
    ) dut (
        .i_clk_ahb    (i_clk_ahb),
        .i_rst_ahb    (i_rst_ahb),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_rd0_wr1(i_req_rd0_wr1),
        .i_req_wr_data(i_req_wr_data),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_addr       (o_addr),
        .o_rd0_wr1    (o_rd0_wr1),
        .o_wr_data    (o_wr_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_rd_valid   (i_rd_valid),
        .i_rd_data    (i_rd_data),
        .o_cmd_level  (o_cmd_level),
        .o_rsp_level  (o_rsp_level),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk_ahb = ~i_clk_ahb;

    // Reference model state
    cmd_t        host_q[$];   // commands the host still wants to send
    cmd_t        cmd_q[$];    // commands held in the block
    logic [31:0] rsp_q[$];    // read data held in the block
    int          pend[$];     // cycle at which each issued read may return
    int          outst;
    bit          m_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_issued = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit rand_mode = 0;
    bit fixed_data = 0;
    bit force_rdv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_t c;
        c.wr = wr;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

    // One clock cycle: drive inputs, compare outputs to the model, clock, update the model.
    task automatic cycle();
        bit   m_ready, m_valid, m_rsp_valid, push, pop, rsp_pop, from_pend;
        cmd_t hd;
        if (rand_mode) begin
            i_ready     = ($urandom_range(0, 3) != 0);
            i_rsp_ready = ($urandom_range(0, 2) != 0);
            if (host_q.size() == 0 && $urandom_range(0, 1) == 1)
                host_q.push_back(mk(1'($urandom_range(0, 1)), $urandom(), $urandom()));
        end
        if (host_q.size() > 0) begin
            i_req_valid   = 1'b1;
            i_req_rd0_wr1 = host_q[0].wr;
            i_req_addr    = host_q[0].addr;
            i_req_wr_data = host_q[0].data;
        end else begin
            i_req_valid   = 1'b0;
            i_req_rd0_wr1 = 1'($urandom_range(0, 1));
            i_req_addr    = $urandom();
            i_req_wr_data = $urandom();
        end
        from_pend  = !force_rdv && pend.size() > 0 && pend[0] <= cyc &&
                     (!rand_mode || $urandom_range(0, 1) == 1);
        i_rd_valid = force_rdv || from_pend;
        i_rd_data  = fixed_data ? 32'hDEAD_BEEF : $urandom();
        #1;

        m_ready     = !i_rst_ahb && cmd_q.size() < DEPTH;
        m_valid     = !i_rst_ahb && cmd_q.size() > 0 &&
                      (cmd_q[0].wr || (outst + rsp_q.size()) < DEPTH);
        m_rsp_valid = !i_rst_ahb && rsp_q.size() > 0;

        chk("req_ready", o_req_ready, m_ready);
        chk("valid", o_valid, m_valid);
        chk("rsp_valid", o_rsp_valid, m_rsp_valid);
        chk("cmd_level", o_cmd_level, i_rst_ahb ? 0 : cmd_q.size());
        chk("rsp_level", o_rsp_level, i_rst_ahb ? 0 : rsp_q.size());
        chk("busy", o_busy, !i_rst_ahb && (cmd_q.size() > 0 || outst != 0));
        chk("err", o_err, !i_rst_ahb && m_err);
        if (m_valid) begin
            chk("head_wr", o_rd0_wr1, cmd_q[0].wr);
            chk("head_addr", o_addr, cmd_q[0].addr);
            if (cmd_q[0].wr) chk("head_data", o_wr_data, cmd_q[0].data);
        end
        if (m_rsp_valid) chk("rsp_data", o_rsp_data, rsp_q[0]);

        push    = i_req_valid && m_ready;
        pop     = m_valid && i_ready;
        rsp_pop = m_rsp_valid && i_rsp_ready;
        if (o_valid && i_ready) obs_issued++;

        @(posedge i_clk_ahb);
        if (i_rst_ahb) begin
            cmd_q.delete();
            rsp_q.delete();
            pend.delete();
            outst = 0;
            m_err = 0;
        end else begin
            if (i_rd_valid) begin
                if (outst > 0) begin
                    rsp_q.push_back(i_rd_data);
                    outst--;
                end else begin
                    m_err = 1;
                end
                if (from_pend) void'(pend.pop_front());
            end
            if (rsp_pop) void'(rsp_q.pop_front());
            if (pop) begin
                hd = cmd_q.pop_front();
                if (!hd.wr) begin
                    outst++;
                    pend.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                end
            end
            if (push) cmd_q.push_back(host_q.pop_front());
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            if (host_q.size() == 0 && cmd_q.size() == 0 && outst == 0 &&
                pend.size() == 0 && rsp_q.size() == 0) begin
                done = 1;
            end else begin
                cycle();
                n++;
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL drain_timeout: observed work pending after %0d cycles, expected idle", n);
        end
    endtask

    initial begin
        outst = 0;
        m_err = 0;
        i_rst_ahb = 1'b1;
        i_ready = 1'b1;
        i_rsp_ready = 1'b0;
        run(2);
        i_rst_ahb = 1'b0;
        run(1);

        // Single write
        host_q.push_back(mk(1'b1, 32'h0000_0010, 32'hA5A5_A5A5));
        run(1);
        chk("wr_valid", o_valid, 1'b1);
        chk("wr_addr", o_addr, 32'h0000_0010);
        chk("wr_data", o_wr_data, 32'hA5A5_A5A5);
        run(2);
        chk("wr_busy_done", o_busy, 1'b0);
        chk("wr_no_rsp", o_rsp_level, 0);

        // Read round-trip with fixed two-cycle return latency
        lat_min = 2;
        lat_max = 2;
        fixed_data = 1;
        host_q.push_back(mk(1'b0, 32'h0000_0020, 32'h0));
        run(6);
        chk("rt_rsp_valid", o_rsp_valid, 1'b1);
        chk("rt_rsp_data", o_rsp_data, 32'hDEAD_BEEF);
        chk("rt_busy", o_busy, 1'b0);
        i_rsp_ready = 1'b1;
        run(1);
        i_rsp_ready = 1'b0;
        chk("rt_popped", o_rsp_level, 0);
        fixed_data = 0;

        // Credit stall: six reads against four response slots
        lat_min = 1;
        lat_max = 1;
        obs_issued = 0;
        for (int i = 0; i < 6; i++) host_q.push_back(mk(1'b0, 32'h100 + 4 * i, 32'h0));
        run(20);
        chk("stall_issued4", obs_issued, 4);
        chk("stall_valid", o_valid, 1'b0);
        chk("stall_cmd_lvl", o_cmd_level, 2);
        chk("stall_rsp_lvl", o_rsp_level, 4);
        i_rsp_ready = 1'b1;
        run(1);
        i_rsp_ready = 1'b0;
        run(4);
        chk("stall_issued5", obs_issued, 5);
        i_rsp_ready = 1'b1;
        run_until_idle(100);

        // Command FIFO full
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) host_q.push_back(mk(1'b1, 32'h200 + 4 * i, $urandom()));
        run(8);
        chk("full_ready", o_req_ready, 1'b0);
        chk("full_level", o_cmd_level, 4);
        i_ready = 1'b1;
        run(1);
        i_ready = 1'b0;
        run(3);
        chk("full_refill", o_cmd_level, 4);
        i_ready = 1'b1;
        run_until_idle(100);

        // Back-to-back reads: accept and return collide, response push and pop collide
        for (int i = 0; i < 6; i++) host_q.push_back(mk(1'b0, 32'h300 + 4 * i, 32'h0));
        run_until_idle(100);

        // Orphan read data sets a sticky error
        force_rdv = 1;
        run(1);
        force_rdv = 0;
        chk("err_set", o_err, 1'b1);
        run(3);
        chk("err_sticky", o_err, 1'b1);

        // Reset with two commands queued
        i_ready = 1'b0;
        host_q.push_back(mk(1'b1, 32'h400, 32'h1));
        host_q.push_back(mk(1'b0, 32'h404, 32'h0));
        run(3);
        chk("pre_rst_level", o_cmd_level, 2);
        i_rst_ahb = 1'b1;
        run(1);
        i_rst_ahb = 1'b0;
        chk("rst_cmd_level", o_cmd_level, 0);
        chk("rst_rsp_level", o_rsp_level, 0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        i_ready = 1'b1;
        run(2);

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        rand_mode = 1;
        run(800);
        rand_mode = 0;
        i_ready = 1'b1;
        i_rsp_ready = 1'b1;
        run_until_idle(200);
        chk("rand_no_err", o_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_txn_queue.md
# ahb_txn_queue

Request/response buffer that sits directly upstream of the AHB master and drives its transaction interface (address, read/write, write data, valid/ready) from a host-side command FIFO. Read data returned by the master as single-cycle pulses, which cannot be stalled, is captured into a response FIFO with host-side backpressure. Read credits guarantee that every read issued has a reserved response slot, so no read data is ever dropped.

## Interface
Parameters:
- DEPTH, 4: entries in each of the command and response FIFOs; power of two, ≥ 2.
- LVL_W, $clog2(DEPTH)+1: width of level/count fields.

Ports:
- i_clk_ahb  in  1  AHB clock; all logic on its rising edge.
- i_rst_ahb  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  host command valid.
- o_req_ready  out  1  command FIFO can accept; = !cmd_full && !i_rst_ahb.
- i_req_addr  in  32  command address.
- i_req_rd0_wr1  in  1  0 = read, 1 = write.
- i_req_wr_data  in  32  write data; ignored for reads.
- o_rsp_valid  out  1  response FIFO non-empty.
- i_rsp_ready  in  1  host pops response.
- o_rsp_data  out  32  head-of-FIFO read data.
- o_addr / o_rd0_wr1 / o_wr_data  out  32/1/32  head command to master.
- o_valid  out  1  head command presented to master.
- i_ready  in  1  master accepts command when o_valid && i_ready.
- i_rd_valid  in  1  one-cycle read-data pulse from master.
- i_rd_data  in  32  read data, qualified by i_rd_valid.
- o_cmd_level  out  LVL_W  command FIFO occupancy.
- o_rsp_level  out  LVL_W  response FIFO occupancy.
- o_busy  out  1  cmd FIFO non-empty or outstanding reads ≠ 0.
- o_err  out  1  sticky: i_rd_valid with zero outstanding reads.

## Operation
- Command FIFO: DEPTH × 65 bits {rd0_wr1, addr, wr_data}; push on i_req_valid && o_req_ready; pop on o_valid && i_ready. Pointers have LVL_W bits; wrap modulo 2·DEPTH; full = MSBs differ, lower bits equal.
- Credit counter `outstanding` (LVL_W bits): reads accepted by the master but whose data has not yet returned.
- Issue gating: o_valid = cmd_nonempty && (head is write || (outstanding + rsp_level) < DEPTH). A blocked read at the head blocks all following commands (strict ordering, no bypass).
- outstanding: +1 on read pop; −1 on i_rd_valid; both in the same cycle → unchanged.
- Response FIFO: push i_rd_data on i_rd_valid when outstanding ≠ 0; pop on o_rsp_valid && i_rsp_ready. Simultaneous push/pop → level unchanged, data order preserved. Push when full cannot occur by construction.
- i_rd_valid with outstanding = 0: data discarded, counters unchanged, o_err set; o_err is cleared only by reset.
- Writes produce no response entry.
- Reset clears pointers, levels, outstanding, and o_err. FIFO storage is not reset. A reset asserted mid-transaction discards all queued and in-flight state; read data arriving after reset raises o_err.

## Timing
- Reset values, and values held while i_rst_ahb = 1: o_req_ready 0, o_valid 0, o_rsp_valid 0, o_cmd_level 0, o_rsp_level 0, o_busy 0, o_err 0, o_rsp_data/o_addr/o_wr_data/o_rd0_wr1 don't-care.
- Command latency: pushed at edge N → o_valid high in cycle N+1 if unblocked (registered FIFO, show-ahead head).
- Response latency: i_rd_valid in cycle M → o_rsp_valid high in cycle M+1.
- o_req_ready and o_rsp_valid are functions of registered state only. o_valid depends only on registered state; it is never combinationally dependent on i_ready, i_rd_valid, or i_req_valid.
- Full throughput: one push and one pop per cycle on each FIFO; a full command FIFO accepts a push in the same cycle as a pop only on the following cycle (o_req_ready is not combinational on i_ready).

## Test plan
- Single write: push wr addr 0x0000_0010, data 0xA5A5_A5A5, i_ready = 1 → o_valid cycle N+1 with matching fields; popped; o_busy falls; o_rsp_level stays 0.
- Read round-trip: push rd 0x20; master returns i_rd_valid with 0xDEAD_BEEF 2 cycles after accept → o_rsp_valid next cycle with 0xDEAD_BEEF; outstanding back to 0.
- Credit stall (DEPTH = 4): hold i_rsp_ready = 0, push 6 reads, return data for each accepted read → exactly 4 issued, o_valid low with reads still queued; pop 1 response → 5th read issues.
- Command full: i_ready = 0, push 5 writes → o_req_ready low after 4, o_cmd_level = 4; 5th push not accepted until a pop.
- Simultaneous events: read accept and i_rd_valid in the same cycle → outstanding unchanged; response push and pop in the same cycle → o_rsp_level unchanged, data order intact.
- Error/reset: i_rd_valid with nothing outstanding → o_err = 1 next cycle and sticky; reset mid-stream with 2 queued commands → all levels 0, o_err 0, o_valid 0 the cycle after.
